// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   import muldiv_unit_pkg::*;

   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] port_a;
   logic [WIDTH-1:0] port_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             zero;
   logic             neg;
   logic             dz;

   modport muldiv (
      input  start, op, port_a, port_b,
      output busy, done, hi, lo, zero, neg, dz
   );

   modport tb (
      output start, op, port_a, port_b,
      input  busy, done, hi, lo, zero, neg, dz
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide on
// magnitudes, with a final sign-correction cycle that writes the HI/LO result pair.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic          CLK,
   input  logic          nRST,
   muldiv_unit_if.muldiv mif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   function automatic logic [W2-1:0] negate(input logic [W2-1:0] v);
      return ~v + W2'(1);
   endfunction

   muldiv_state_t    state_q, state_d;
   muldiv_op_t       op_q, op_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             dz_pend_q, dz_pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             dz_q, dz_d;

   logic             in_signed;
   logic             in_div;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             op_signed;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   div_diff;
   logic [W2-1:0]    mul_next;
   logic [W2-1:0]    div_next;
   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= ST_IDLE;
         op_q      <= MD_MULT;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         dz_pend_q <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         dz_pend_q <= dz_pend_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         zero_q    <= zero_d;
         neg_q     <= neg_d;
         dz_q      <= dz_d;
      end
   end

   always_comb begin
      in_signed = SIGNED_EN && !mif.op[0];
      in_div    = mif.op[1];
      a_mag     = (in_signed && mif.port_a[WIDTH-1]) ?
                  WIDTH'(negate({{WIDTH{1'b0}}, mif.port_a})) : mif.port_a;
      b_mag     = (in_signed && mif.port_b[WIDTH-1]) ?
                  WIDTH'(negate({{WIDTH{1'b0}}, mif.port_b})) : mif.port_b;
      op_signed = SIGNED_EN && !op_q[0];

      // Multiply step: conditionally add multiplier to the upper half, then shift right.
      mul_sum  = acc_q[0] ? ({1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q})
                          : {1'b0, acc_q[W2-1:WIDTH]};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide step: the remainder is one bit wider during the trial subtract.
      rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = rem_sh - {1'b0, b_q};
      div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod   = (op_signed && (sign_a_q ^ sign_b_q)) ? negate(acc_q) : acc_q;
      fix_hi = prod[W2-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (dz_pend_q) begin
         fix_hi = acc_q[WIDTH-1:0];
         fix_lo = '1;
      end else if (op_q[1]) begin
         fix_lo = (op_signed && (sign_a_q ^ sign_b_q)) ?
                  WIDTH'(negate({{WIDTH{1'b0}}, acc_q[WIDTH-1:0]})) : acc_q[WIDTH-1:0];
         fix_hi = (op_signed && sign_a_q) ?
                  WIDTH'(negate({{WIDTH{1'b0}}, acc_q[W2-1:WIDTH]})) : acc_q[W2-1:WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      dz_pend_d = dz_pend_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
      dz_d      = dz_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (mif.start) begin
               op_d     = mif.op;
               sign_a_d = in_signed && mif.port_a[WIDTH-1];
               sign_b_d = in_signed && mif.port_b[WIDTH-1];
               b_d      = b_mag;
               if (in_div && (mif.port_b == '0)) begin
                  dz_pend_d = 1'b1;
                  acc_d     = {{WIDTH{1'b0}}, mif.port_a};
                  cnt_d     = '0;
                  state_d   = ST_FIX;
               end else begin
                  dz_pend_d = 1'b0;
                  acc_d     = {{WIDTH{1'b0}}, a_mag};
                  cnt_d     = CNT_W'(WIDTH);
                  state_d   = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            zero_d  = (fix_hi == '0) && (fix_lo == '0);
            neg_d   = op_q[1] ? fix_lo[WIDTH-1] : fix_hi[WIDTH-1];
            dz_d    = dz_pend_q;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mif.busy = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign mif.done = (state_q == ST_DONE);
   assign mif.hi   = hi_q;
   assign mif.lo   = lo_q;
   assign mif.zero = zero_q;
   assign mif.neg  = neg_q;
   assign mif.dz   = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): hand-computed products, quotients,
// flags and handshake timing, including back-to-back, divide-by-zero and mid-op reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic nrst;
   int   total = 0;
   int   bad = 0;
   int   done_cyc;
   int   busy_cnt;

   muldiv_unit_if #(.WIDTH(32)) mif ();

   muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .mif  (mif)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; returns at the falling edge where done is seen
   // (or after the cycle budget). Cycle 1 is the cycle after the start edge.
   task automatic apply_stimulus(input muldiv_op_t op, input logic [31:0] a,
                                 input logic [31:0] b, input int pulse_at);
      mif.start  = 1'b1;
      mif.op     = op;
      mif.port_a = a;
      mif.port_b = b;
      @(negedge clk);
      mif.start  = 1'b0;
      mif.port_a = ~a;
      mif.port_b = ~b;
      done_cyc   = 1;
      busy_cnt   = 0;
      while (!mif.done && done_cyc < 60) begin
         if (mif.busy) busy_cnt++;
         mif.start = (done_cyc == pulse_at);
         if (done_cyc == pulse_at) begin
            mif.op     = MD_DIVU;
            mif.port_a = 32'd1;
            mif.port_b = 32'd0;
         end
         @(negedge clk);
         done_cyc++;
      end
   endtask

   initial begin
      mif.start  = 1'b0;
      mif.op     = MD_MULT;
      mif.port_a = '0;
      mif.port_b = '0;
      nrst       = 1'b1;
      #2 nrst = 1'b0;
      #1;
      check_output("rst_busy", 32'(mif.busy), 32'd0);
      check_output("rst_done", 32'(mif.done), 32'd0);
      check_output("rst_hi",   mif.hi,        32'd0);
      check_output("rst_lo",   mif.lo,        32'd0);
      check_output("rst_dz",   32'(mif.dz),   32'd0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      apply_stimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check_output("multu_done_cyc", 32'(done_cyc), 32'd34);
      check_output("multu_busy_cnt", 32'(busy_cnt), 32'd33);
      check_output("multu_busy_at_done", 32'(mif.busy), 32'd0);
      check_output("multu_hi", mif.hi, 32'hFFFF_FFFE);
      check_output("multu_lo", mif.lo, 32'h0000_0001);
      check_output("multu_neg", 32'(mif.neg), 32'd1);
      @(negedge clk);
      check_output("done_one_cycle", 32'(mif.done), 32'd0);
      check_output("hi_hold_idle", mif.hi, 32'hFFFF_FFFE);

      apply_stimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7, 0);
      check_output("mult_neg3x7_hi", mif.hi, 32'hFFFF_FFFF);
      check_output("mult_neg3x7_lo", mif.lo, 32'hFFFF_FFEB);
      check_output("mult_neg3x7_neg", 32'(mif.neg), 32'd1);
      check_output("mult_neg3x7_zero", 32'(mif.zero), 32'd0);
      @(negedge clk);

      apply_stimulus(MD_MULT, 32'd0, 32'd5, 0);
      check_output("mult_zero_lo", mif.lo, 32'd0);
      check_output("mult_zero_zero", 32'(mif.zero), 32'd1);
      check_output("mult_zero_neg", 32'(mif.neg), 32'd0);
      @(negedge clk);

      apply_stimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      check_output("div_neg7_2_lo", mif.lo, 32'hFFFF_FFFD);
      check_output("div_neg7_2_hi", mif.hi, 32'hFFFF_FFFF);
      apply_stimulus(MD_DIVU, 32'd7, 32'd2, 0);
      check_output("b2b_divu_done_cyc", 32'(done_cyc), 32'd34);
      check_output("b2b_divu_lo", mif.lo, 32'd3);
      check_output("b2b_divu_hi", mif.hi, 32'd1);
      @(negedge clk);

      apply_stimulus(MD_DIVU, 32'd100, 32'd0, 0);
      check_output("dz_done_cyc", 32'(done_cyc), 32'd2);
      check_output("dz_flag", 32'(mif.dz), 32'd1);
      check_output("dz_lo", mif.lo, 32'hFFFF_FFFF);
      check_output("dz_hi", mif.hi, 32'h0000_0064);
      @(negedge clk);

      apply_stimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check_output("ovf_lo", mif.lo, 32'h8000_0000);
      check_output("ovf_hi", mif.hi, 32'd0);
      check_output("ovf_dz_cleared", 32'(mif.dz), 32'd0);
      check_output("ovf_neg", 32'(mif.neg), 32'd1);
      @(negedge clk);

      apply_stimulus(MD_MULT, 32'd5, 32'd6, 10);
      check_output("busy_start_done_cyc", 32'(done_cyc), 32'd34);
      check_output("busy_start_lo", mif.lo, 32'h0000_001E);
      check_output("busy_start_hi", mif.hi, 32'd0);
      check_output("busy_start_dz", 32'(mif.dz), 32'd0);
      @(negedge clk);

      mif.start  = 1'b1;
      mif.op     = MD_DIV;
      mif.port_a = 32'd100;
      mif.port_b = 32'd7;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (14) @(negedge clk);
      check_output("pre_rst_busy", 32'(mif.busy), 32'd1);
      nrst = 1'b0;
      #1;
      check_output("midrst_busy", 32'(mif.busy), 32'd0);
      check_output("midrst_done", 32'(mif.done), 32'd0);
      check_output("midrst_hi",   mif.hi,        32'd0);
      check_output("midrst_lo",   mif.lo,        32'd0);
      check_output("midrst_zero", 32'(mif.zero), 32'd0);
      check_output("midrst_neg",  32'(mif.neg),  32'd0);
      check_output("midrst_dz",   32'(mif.dz),   32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check_output("post_rst_idle_busy", 32'(mif.busy), 32'd0);
      check_output("post_rst_idle_done", 32'(mif.done), 32'd0);

      apply_stimulus(MD_DIVU, 32'd100, 32'd7, 0);
      check_output("after_rst_done_cyc", 32'(done_cyc), 32'd34);
      check_output("after_rst_lo", mif.lo, 32'd14);
      check_output("after_rst_hi", mif.hi, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
